// File: rtl/stream_cnt_src.sv
// Counting valid/ready stream source: emits 0,1,2,... up to a sampled limit.
// Optional STREAM_CNT_SRC_WRAPCNT_EN adds a saturating wrap counter on wraps_o.
module stream_cnt_src #(
    parameter int   Width = 8,
    parameter logic Wrap  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic [Width-1:0] limit_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
    ,
    output logic [15:0]      wraps_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] lim_q, lim_d;
    logic [Width-1:0] cnt_nxt;
    logic             in_stream;
    logic             accept;
    logic             at_lim;
    logic             hit;

    assign in_stream = (state_q == S_RUN) || (state_q == S_STOP);
    assign accept    = in_stream && ready_i;
    assign at_lim    = (cnt_q == lim_q);
    assign hit       = at_lim && !Wrap;

    assign data_o  = cnt_q;
    assign valid_o = in_stream;
    assign busy_o  = in_stream;
    assign done_o  = (state_q == S_DONE);

    // Value the count takes when the current beat is accepted.
    always_comb begin
        cnt_nxt = cnt_q + Width'(1);
        if (at_lim) begin
            cnt_nxt = Wrap ? '0 : cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        case (state_q)
            S_IDLE: begin
                if (clear_i) begin
                    cnt_d = '0;
                end
                if (start_i) begin
                    lim_d   = limit_i;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    cnt_d = cnt_nxt;
                    if (hit) begin
                        state_d = S_DONE;
                    end else if (stop_i) begin
                        state_d = S_IDLE;
                    end
                end else if (stop_i) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (accept) begin
                    cnt_d   = cnt_nxt;
                    state_d = hit ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    cnt_d   = '0;
                    lim_d   = limit_i;
                    state_d = S_RUN;
                end else if (clear_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
        end
    end

`ifdef STREAM_CNT_SRC_WRAPCNT_EN
    logic [15:0] wraps_q, wraps_d;
    logic        wrap_ev;
    logic        wraps_clr;

    assign wrap_ev   = accept && at_lim && Wrap;
    assign wraps_clr = clear_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        wraps_d = wraps_q;
        if (wraps_clr) begin
            wraps_d = '0;
        end else if (wrap_ev && (wraps_q != 16'hFFFF)) begin
            wraps_d = wraps_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wraps_q <= '0;
        end else begin
            wraps_q <= wraps_d;
        end
    end

    assign wraps_o = wraps_q;
`endif

endmodule

// File: tb/tb_stream_cnt_src.sv
// Scoreboard bench for stream_cnt_src: stop/limit, wrapping and
// 4-bit full-width wrap instances share one clock and reset.
module tb_stream_cnt_src;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       start0 = 0, stop0 = 0, clear0 = 0, rdy0 = 0;
    logic [7:0] lim0 = 0, d0;
    logic       v0, b0, dn0;

    logic       start1 = 0, stop1 = 0, clear1 = 0, rdy1 = 0;
    logic [7:0] lim1 = 0, d1;
    logic       v1, b1, dn1;

    logic       start2 = 0, stop2 = 0, clear2 = 0, rdy2 = 0;
    logic [3:0] lim2 = 0, d2;
    logic       v2, b2, dn2;

`ifdef STREAM_CNT_SRC_WRAPCNT_EN
    logic [15:0] w0, w1, w2;
`endif

    stream_cnt_src #(.Width(8), .Wrap(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .stop_i(stop0),
        .clear_i(clear0), .limit_i(lim0), .data_o(d0), .valid_o(v0),
        .ready_i(rdy0), .busy_o(b0), .done_o(dn0)
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
        , .wraps_o(w0)
`endif
    );

    stream_cnt_src #(.Width(8), .Wrap(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .stop_i(stop1),
        .clear_i(clear1), .limit_i(lim1), .data_o(d1), .valid_o(v1),
        .ready_i(rdy1), .busy_o(b1), .done_o(dn1)
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
        , .wraps_o(w1)
`endif
    );

    stream_cnt_src #(.Width(4), .Wrap(1'b1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .stop_i(stop2),
        .clear_i(clear2), .limit_i(lim2), .data_o(d2), .valid_o(v2),
        .ready_i(rdy2), .busy_o(b2), .done_o(dn2)
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
        , .wraps_o(w2)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [3:0] q2[$];

    // Random-wait slave on instance 0: 0..3 idle cycles between beats.
    bit rnd = 0;
    int wl  = 0;
    always @(posedge clk) begin
        #1;
        if (rnd) begin
            if (wl > 0) begin
                rdy0 = 1'b0;
                wl--;
            end else begin
                rdy0 = 1'b1;
                if (v0) wl = $urandom_range(0, 3);
            end
        end
    end

    logic       stall0 = 0;
    logic [7:0] hd0;
    always @(negedge clk) begin
        if (rst) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                check("hold_valid", 32'(v0), 32'd1);
                check("hold_data", 32'(d0), 32'(hd0));
            end
            stall0 = v0 && !rdy0;
            hd0    = d0;
            if (v0 && rdy0) begin
                if (q0.size() == 0) check("sb0_extra", q0.size(), 1);
                else check("sb0_data", 32'(d0), 32'(q0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && v1 && rdy1) begin
            if (q1.size() == 0) check("sb1_extra", q1.size(), 1);
            else check("sb1_data", 32'(d1), 32'(q1.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && v2 && rdy2) begin
            if (q2.size() == 0) check("sb2_extra", q2.size(), 1);
            else check("sb2_data", 32'(d2), 32'(q2.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input int n);
        for (int i = 0; i < n && !dn0; i++) tick();
        check("done_timeout", 32'(dn0), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_data", 32'(d0), 32'd0);
        check("rst_valid", 32'(v0), 32'd0);
        check("rst_busy", 32'(b0), 32'd0);
        check("rst_done", 32'(dn0), 32'd0);

        // Limit 5 at full throughput; later limit_i change is ignored.
        lim0 = 8'd5;
        rdy0 = 1'b1;
        for (int i = 0; i <= 5; i++) q0.push_back(8'(i));
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        lim0   = 8'd2;
        check("t1_first_valid", 32'(v0), 32'd1);
        check("t1_first_data", 32'(d0), 32'd0);
        check("t1_busy", 32'(b0), 32'd1);
        repeat (5) tick();
        check("t1_last_data", 32'(d0), 32'd5);
        check("t1_last_valid", 32'(v0), 32'd1);
        tick();
        check("t1_done", 32'(dn0), 32'd1);
        check("t1_valid_off", 32'(v0), 32'd0);
        check("t1_busy_off", 32'(b0), 32'd0);
        check("t1_sb_empty", q0.size(), 0);

        // Same run under random backpressure, restarted from DONE.
        lim0 = 8'd5;
        for (int i = 0; i <= 5; i++) q0.push_back(8'(i));
        rnd    = 1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(200);
        rnd  = 0;
        rdy0 = 1'b1;
        check("t2_sb_empty", q0.size(), 0);
        check("t2_data", 32'(d0), 32'd5);

        // Stop under backpressure at value 3, then resume at 4.
        lim0 = 8'd9;
        for (int i = 0; i <= 3; i++) q0.push_back(8'(i));
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (3) tick();
        check("t4_at3", 32'(d0), 32'd3);
        rdy0  = 1'b0;
        stop0 = 1'b1;
        tick();
        stop0 = 1'b0;
        check("t4_stop_valid", 32'(v0), 32'd1);
        check("t4_stop_data", 32'(d0), 32'd3);
        check("t4_stop_busy", 32'(b0), 32'd1);
        start0 = 1'b1;
        repeat (2) tick();
        start0 = 1'b0;
        check("t4_hold_data", 32'(d0), 32'd3);
        rdy0 = 1'b1;
        tick();
        check("t4_idle_valid", 32'(v0), 32'd0);
        check("t4_idle_busy", 32'(b0), 32'd0);
        check("t4_idle_done", 32'(dn0), 32'd0);
        check("t4_idle_cnt", 32'(d0), 32'd4);
        for (int i = 4; i <= 9; i++) q0.push_back(8'(i));
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("t4_resume", 32'(d0), 32'd4);
        wait_done0(50);
        check("t4_sb_empty", q0.size(), 0);

        // Limit 0 emits a single 0.
        lim0 = 8'd0;
        q0.push_back(8'd0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("l0_valid", 32'(v0), 32'd1);
        check("l0_data", 32'(d0), 32'd0);
        tick();
        check("l0_done", 32'(dn0), 32'd1);
        check("l0_valid_off", 32'(v0), 32'd0);

        // Wrapping instance, limit 2, 8 beats then stop.
        lim1 = 8'd2;
        rdy1 = 1'b1;
        for (int i = 0; i < 8; i++) q1.push_back(8'(i % 3));
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (7) tick();
        check("t3_beat8", 32'(d1), 32'd1);
        stop1 = 1'b1;
        tick();
        stop1 = 1'b0;
        check("t3_idle_valid", 32'(v1), 32'd0);
        check("t3_idle_busy", 32'(b1), 32'd0);
        check("t3_cnt", 32'(d1), 32'd2);
        check("t3_sb_empty", q1.size(), 0);
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
        check("t3_wraps", 32'(w1), 32'd2);
`endif

        // 4-bit instance wraps 15 -> 0 at full width.
        lim2 = 4'd15;
        rdy2 = 1'b1;
        for (int i = 0; i < 18; i++) q2.push_back(4'(i % 16));
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (17) tick();
        check("t5_data", 32'(d2), 32'd1);
        stop2 = 1'b1;
        tick();
        stop2 = 1'b0;
        check("t5_idle_valid", 32'(v2), 32'd0);
        check("t5_cnt", 32'(d2), 32'd2);
        check("t5_sb_empty", q2.size(), 0);
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
        check("t5_wraps", 32'(w2), 32'd1);
`endif

        // Reset while value 7 is on the stream.
        lim0 = 8'd20;
        for (int i = 0; i <= 6; i++) q0.push_back(8'(i));
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        check("t6_at7_data", 32'(d0), 32'd7);
        check("t6_at7_valid", 32'(v0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_data", 32'(d0), 32'd0);
        check("t6_rst_valid", 32'(v0), 32'd0);
        check("t6_rst_busy", 32'(b0), 32'd0);
        check("t6_rst_done", 32'(dn0), 32'd0);
        check("t6_sb_empty", q0.size(), 0);
`ifdef STREAM_CNT_SRC_WRAPCNT_EN
        check("t6_rst_wraps", 32'(w1), 32'd0);
`endif
        lim0 = 8'd2;
        for (int i = 0; i <= 2; i++) q0.push_back(8'(i));
        clear0 = 1'b1;
        start0 = 1'b1;
        tick();
        clear0 = 1'b0;
        start0 = 1'b0;
        check("t6_restart_valid", 32'(v0), 32'd1);
        check("t6_restart_data", 32'(d0), 32'd0);
        wait_done0(20);
        check("t6_sb_empty2", q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
